// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte requesters / UART transmitter and the arbiter.
// The slave view is the arbiter itself; the master view is its environment
// (protocol logic on the request side, the transmitter on the Tx side).
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              TxEn;
  logic [7:0]        TxData;
  logic              TxDone;
  logic              busy;
  logic [GW-1:0]     grant_id;
  logic              timeout_err;

  modport master (
    output req_valid, req_last, req_data, TxDone,
    input  req_ready, TxEn, TxData, busy, grant_id, timeout_err
  );

  modport slave (
    input  req_valid, req_last, req_data, TxDone,
    output req_ready, TxEn, TxData, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte
// requesters. A packet keeps its grant until its last byte; every byte is
// loaded into TxData, started with an EN_CYCLES-long TxEn strobe and then
// waits for the transmitter's TxDone level (synchronized here) or a timeout.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 65535,
  parameter int EN_CYCLES = 2
) (
  input logic              Clk,
  input logic              Rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int EW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam logic [GW-1:0]   LAST_IDX = GW'(NREQ - 1);
  localparam logic [CW-1:0]   WAIT_MAX = CW'(TIMEOUT - 1);
  localparam logic [EW-1:0]   EN_MAX   = EW'(EN_CYCLES - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [2:0]      state_reg, state_next;
  logic            done_meta_reg, done_s_reg, done_d_reg;
  logic            done_rise;
  logic            lock_reg, lock_next;
  logic [GW-1:0]   last_grant_reg, last_grant_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [NREQ-1:0] ready_reg, ready_next;
  logic            tx_en_reg, tx_en_next;
  logic [7:0]      tx_data_reg, tx_data_next;
  logic            timeout_reg, timeout_next;
  logic [EW-1:0]   en_cnt_reg, en_cnt_next;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;

  // Candidate requesters in search order: cand[0] is last_grant+1, wrapping.
  logic [GW-1:0]   cand [NREQ];
  logic [NREQ-1:0] cand_valid;
  logic [GW-1:0]   pick;
  logic            hit;

  assign done_rise = done_s_reg & ~done_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      // Rotate the requester index so that offset gi follows last_grant.
      always_comb begin
        int s;
        s = int'(last_grant_reg) + 1 + gi;
        if (s >= NREQ) s = s - NREQ;
        cand[gi] = GW'(s);
      end
      assign cand_valid[gi] = bus.req_valid[cand[gi]];
    end
  endgenerate

  // Arbitration: a locked packet only lets its own requester through,
  // otherwise the first valid candidate after last_grant wins.
  always_comb begin
    hit  = 1'b0;
    pick = grant_reg;
    if (lock_reg) begin
      hit  = bus.req_valid[grant_reg];
      pick = grant_reg;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (cand_valid[k]) begin
          hit  = 1'b1;
          pick = cand[k];
        end
      end
    end
  end

  // Next-state and datapath decisions for the byte sequencer.
  always_comb begin
    state_next      = state_reg;
    lock_next       = lock_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    ready_next      = '0;
    tx_en_next      = tx_en_reg;
    tx_data_next    = tx_data_reg;
    timeout_next    = 1'b0;
    en_cnt_next     = en_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          grant_next = pick;
          ready_next = ONE_HOT0 << pick;
          state_next = LOAD;
        end
      end
      LOAD: begin
        // Requester still holds its lane during the ready pulse.
        tx_data_next    = bus.req_data[8*grant_reg +: 8];
        lock_next       = ~bus.req_last[grant_reg];
        last_grant_next = grant_reg;
        en_cnt_next     = '0;
        tx_en_next      = 1'b1;
        state_next      = START;
      end
      START: begin
        if (en_cnt_reg == EN_MAX) begin
          tx_en_next    = 1'b0;
          wait_cnt_next = '0;
          state_next    = WAIT_DONE;
        end else begin
          en_cnt_next = en_cnt_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        // A done edge in the same cycle as the limit still counts as done.
        if (done_rise) begin
          state_next = GAP;
        end else if (wait_cnt_reg == WAIT_MAX) begin
          timeout_next = 1'b1;
          lock_next    = 1'b0;
          state_next   = GAP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        // The transmitter ignores a new start while its done level is high.
        if (!done_s_reg) state_next = IDLE;
      end
      default: begin
        tx_en_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Two-flop synchronizer for TxDone plus one delay stage for edge detection.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      done_meta_reg <= 1'b0;
      done_s_reg    <= 1'b0;
      done_d_reg    <= 1'b0;
    end else begin
      done_meta_reg <= bus.TxDone;
      done_s_reg    <= done_meta_reg;
      done_d_reg    <= done_s_reg;
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg      <= IDLE;
      lock_reg       <= 1'b0;
      last_grant_reg <= LAST_IDX;
      grant_reg      <= '0;
      ready_reg      <= '0;
      tx_en_reg      <= 1'b0;
      tx_data_reg    <= 8'h00;
      timeout_reg    <= 1'b0;
      en_cnt_reg     <= '0;
      wait_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      lock_reg       <= lock_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      ready_reg      <= ready_next;
      tx_en_reg      <= tx_en_next;
      tx_data_reg    <= tx_data_next;
      timeout_reg    <= timeout_next;
      en_cnt_reg     <= en_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

  assign bus.req_ready   = ready_reg;
  assign bus.TxEn        = tx_en_reg;
  assign bus.TxData      = tx_data_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.grant_id    = grant_reg;
  assign bus.timeout_err = timeout_reg;
endmodule
